// File: rtl/pmc_sequencer.sv
// Control and operand stage for a 16-bit ALU: fetches microinstructions, drives operands,
// writes results back to a 16x16 register file, keeps C/S/Z flags and sequences the PC.
module pmc_sequencer #(
  parameter int unsigned PROG_AW = 6,
  parameter int unsigned DW      = 16,
  parameter int unsigned IW      = 36
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PROG_AW-1:0] prog_addr,
  input  logic [IW-1:0]      prog_data,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic               alu_cin,
  output logic               alu_valid,
  input  logic [DW-1:0]      alu_result,
  input  logic               alu_cout,
  input  logic               host_we,
  input  logic [3:0]         host_addr,
  input  logic [DW-1:0]      host_wdata,
  output logic [DW-1:0]      host_rdata,
  output logic [2:0]         flags,
  output logic               busy,
  output logic               done,
  output logic [PROG_AW-1:0] pc
);

  localparam int unsigned RF_AW  = 4;
  localparam int unsigned RF_N   = 16;
  localparam int unsigned FLAG_W = 3;

  localparam logic [1:0] FLOW_NEXT  = 2'b00;
  localparam logic [1:0] FLOW_JCOND = 2'b01;
  localparam logic [1:0] FLOW_JUMP  = 2'b10;
  localparam logic [1:0] FLOW_HALT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PROG_AW-1:0]  pc_q, pc_d;
  logic [PROG_AW-1:0]  prog_addr_q, prog_addr_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [DW-1:0]       alu_a_q, alu_a_d;
  logic [DW-1:0]       alu_b_q, alu_b_d;
  logic                alu_cin_q, alu_cin_d;
  logic                alu_valid_q, alu_valid_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [DW-1:0]       rf_q [RF_N];
  logic                rf_we;
  logic [RF_AW-1:0]    rf_waddr;
  logic [DW-1:0]       rf_wdata;

  logic [PROG_AW-1:0]  pc_inc;
  logic [PROG_AW-1:0]  jump_tgt;
  logic [PROG_AW-1:0]  pc_next;
  logic [1:0]          flow;
  logic                unused_ir;

  assign flow     = ir_q[33:32];
  assign jump_tgt = ir_q[16 +: PROG_AW];
  assign pc_inc   = pc_q + PROG_AW'(1);
  assign unused_ir = ^ir_q;

  // Next PC: wrap comes for free from the fixed PC width; jump and wrap are independent.
  always_comb begin
    pc_next = pc_inc;
    unique case (flow)
      FLOW_JCOND: pc_next = alu_result[DW-1] ? jump_tgt : pc_inc;
      FLOW_JUMP:  pc_next = jump_tgt;
      default:    pc_next = pc_inc;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      prog_addr_q <= '0;
      ir_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_valid_q <= 1'b0;
      flags_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      prog_addr_q <= prog_addr_d;
      ir_q        <= ir_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_valid_q <= alu_valid_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    prog_addr_d = prog_addr_q;
    ir_d        = ir_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    alu_valid_d = 1'b0;
    flags_d     = flags_q;
    done_d      = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = ir_q[3:0];
    rf_wdata    = alu_result;

    unique case (state_q)
      S_IDLE: begin
        if (host_we) begin
          rf_we    = 1'b1;
          rf_waddr = host_addr;
          rf_wdata = host_wdata;
        end
        if (start) begin
          state_d     = S_FETCH;
          pc_d        = '0;
          prog_addr_d = '0;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Operands come straight from the fetched word so they are stable for all of EXEC.
        ir_d        = prog_data;
        alu_a_d     = rf_q[prog_data[7:4]];
        alu_b_d     = prog_data[12] ? DW'(prog_data[31:16]) : rf_q[prog_data[11:8]];
        alu_cin_d   = prog_data[14] ? flags_q[2] : prog_data[15];
        alu_valid_d = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        done_d  = (flow == FLOW_HALT);
        state_d = S_WB;
      end
      S_WB: begin
        rf_we   = ir_q[13];
        flags_d = {alu_cout, alu_result[DW-1], (alu_result == '0)};
        if (flow == FLOW_HALT) begin
          state_d = S_IDLE;
        end else begin
          pc_d        = pc_next;
          prog_addr_d = pc_next;
          state_d     = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (reset) begin
      rf_we = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // Register file has no reset; only one writer is active in any given state.
  always_ff @(posedge clk) begin
    if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign host_rdata = rf_q[host_addr];
  assign prog_addr  = prog_addr_q;
  assign pc         = pc_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign alu_valid  = alu_valid_q;
  assign flags      = flags_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pmc_sequencer.sv
// Directed bench for pmc_sequencer with a synchronous program memory and an adder as the ALU.
module tb_pmc_sequencer;

  localparam int unsigned PROG_AW = 6;
  localparam int unsigned DW      = 16;
  localparam int unsigned IW      = 36;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [PROG_AW-1:0] prog_addr;
  logic [IW-1:0]      prog_data;
  logic [DW-1:0]      alu_a;
  logic [DW-1:0]      alu_b;
  logic               alu_cin;
  logic               alu_valid;
  logic [DW-1:0]      alu_result;
  logic               alu_cout;
  logic               host_we;
  logic [3:0]         host_addr;
  logic [DW-1:0]      host_wdata;
  logic [DW-1:0]      host_rdata;
  logic [2:0]         flags;
  logic               busy;
  logic               done;
  logic [PROG_AW-1:0] pc;

  logic [IW-1:0] pmem [64];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int n_exec  = 0;
  int exec0;

  always #5 clk = ~clk;

  pmc_sequencer #(.PROG_AW(PROG_AW), .DW(DW), .IW(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_valid  (alu_valid),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .flags      (flags),
    .busy       (busy),
    .done       (done),
    .pc         (pc)
  );

  always @(posedge clk) prog_data <= pmem[prog_addr];
  assign {alu_cout, alu_result} = 17'(alu_a) + 17'(alu_b) + 17'(alu_cin);
  always @(posedge clk) if (alu_valid === 1'b1) n_exec++;

  function automatic logic [IW-1:0] mk(input logic [1:0] flow, input logic [15:0] imm,
                                       input logic cinsel, input logic cinv, input logic wb,
                                       input logic bimm, input logic [3:0] b,
                                       input logic [3:0] a, input logic [3:0] d);
    return {2'b00, flow, imm, cinv, cinsel, wb, bimm, b, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hw(input logic [3:0] a, input logic [DW-1:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [DW-1:0] exp);
    host_addr = a;
    #1;
    check(tag, 36'(host_rdata), 36'(exp));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 64; i++) pmem[i] = mk(2'b11, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick(); tick(); tick();
    check("rst_busy", 36'(busy), 36'(0));
    check("rst_done", 36'(done), 36'(0));
    check("rst_pc", 36'(pc), 36'(0));
    check("rst_flags", 36'(flags), 36'(0));
    check("rst_valid", 36'(alu_valid), 36'(0));
    check("rst_alu_a", 36'(alu_a), 36'(0));
    check("rst_alu_b", 36'(alu_b), 36'(0));
    check("rst_cin", 36'(alu_cin), 36'(0));
    check("rst_paddr", 36'(prog_addr), 36'(0));
    reset = 1'b0;
    tick();

    // Single add-and-halt: R3 = 0x7FFF + 0x0001
    hw(4'd1, 16'h7FFF); hw(4'd2, 16'h0001);
    pmem[0] = mk(2'b11, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd3);
    start = 1'b1; tick(); start = 1'b0;               // cycle 1
    check("t1_busy_c1", 36'(busy), 36'(1));
    check("t1_paddr_c1", 36'(prog_addr), 36'(0));
    tick();                                           // cycle 2
    check("t1_valid_c2", 36'(alu_valid), 36'(0));
    tick();                                           // cycle 3
    check("t1_valid_c3", 36'(alu_valid), 36'(1));
    check("t1_alu_a", 36'(alu_a), 36'(16'h7FFF));
    check("t1_alu_b", 36'(alu_b), 36'(16'h0001));
    check("t1_cin", 36'(alu_cin), 36'(0));
    tick();                                           // cycle 4
    check("t1_done_c4", 36'(done), 36'(1));
    check("t1_valid_c4", 36'(alu_valid), 36'(0));
    tick();                                           // cycle 5
    check("t1_done_c5", 36'(done), 36'(0));
    check("t1_busy_c5", 36'(busy), 36'(0));
    check("t1_flags", 36'(flags), 36'(3'b010));
    check("t1_pc", 36'(pc), 36'(0));
    check("t1_alu_a_hold", 36'(alu_a), 36'(16'h7FFF));
    rd("t1_r3", 4'd3, 16'h8000);

    // Carry chain: R3 = 0xFFFF + 1, then R4 = R0 + R0 + C
    hw(4'd0, 16'h0000); hw(4'd1, 16'hFFFF); hw(4'd2, 16'h0001); hw(4'd4, 16'hAAAA);
    pmem[0] = mk(2'b00, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd3);
    pmem[1] = mk(2'b11, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd4);
    start = 1'b1; tick(); start = 1'b0;               // cycle 1
    repeat (4) tick();                                // cycle 5
    check("t2_flags_mid", 36'(flags), 36'(3'b101));
    check("t2_pc_mid", 36'(pc), 36'(1));
    check("t2_paddr_mid", 36'(prog_addr), 36'(1));
    tick(); tick();                                   // cycle 7
    check("t2_valid", 36'(alu_valid), 36'(1));
    check("t2_cin", 36'(alu_cin), 36'(1));
    check("t2_alu_a", 36'(alu_a), 36'(0));
    tick(); tick();                                   // cycle 9
    check("t2_busy_end", 36'(busy), 36'(0));
    check("t2_flags_end", 36'(flags), 36'(3'b000));
    rd("t2_r3", 4'd3, 16'h0000);
    rd("t2_r4", 4'd4, 16'h0001);

    // Conditional jump taken then not taken, immediate operand, start held, host write while busy
    hw(4'd0, 16'h0000); hw(4'd1, 16'h7FFF); hw(4'd2, 16'h0001); hw(4'd7, 16'h5A5A);
    pmem[0]  = mk(2'b01, 16'h002A, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd3);
    pmem[42] = mk(2'b01, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 4'd6);
    pmem[43] = mk(2'b11, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7);
    exec0 = n_exec;
    start = 1'b1; tick();                             // cycle 1
    tick();                                           // cycle 2
    host_we = 1'b1; host_addr = 4'd7; host_wdata = 16'h1111;
    tick(); host_we = 1'b0;                           // cycle 3
    tick(); tick();                                   // cycle 5
    check("t3_pc_taken", 36'(pc), 36'(6'h2A));
    check("t3_paddr_taken", 36'(prog_addr), 36'(6'h2A));
    repeat (4) tick();                                // cycle 9
    check("t3_pc_not_taken", 36'(pc), 36'(6'h2B));
    tick(); tick();                                   // cycle 11
    check("t3_valid", 36'(alu_valid), 36'(1));
    check("t3_imm_b", 36'(alu_b), 36'(16'h1234));
    tick();                                           // cycle 12
    check("t3_done", 36'(done), 36'(1));
    start = 1'b0;
    tick();                                           // cycle 13
    check("t3_busy_end", 36'(busy), 36'(0));
    check("t3_pc_hold", 36'(pc), 36'(6'h2B));
    check("t3_exec_count", 36'(n_exec - exec0), 36'(3));
    rd("t3_r7_kept", 4'd7, 16'h5A5A);
    rd("t3_r6", 4'd6, 16'h7FFF);
    rd("t3_r3", 4'd3, 16'h8000);

    // PC wrap loop 0 -> 1 -> 63 -> 0, then reset during EXEC of a writeback instruction
    hw(4'd0, 16'h0000); hw(4'd1, 16'h7FFF); hw(4'd2, 16'h0001);
    hw(4'd5, 16'hBEEF); hw(4'd8, 16'h0123);
    pmem[0]  = mk(2'b01, 16'h002A, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd3);
    pmem[1]  = mk(2'b10, 16'h003F, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 4'd3);
    pmem[63] = mk(2'b00, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd8, 4'd8);
    start = 1'b1; tick(); start = 1'b0;               // cycle 1
    repeat (4) tick();                                // cycle 5
    check("t4_pc_nt0", 36'(pc), 36'(1));
    repeat (4) tick();                                // cycle 9
    check("t4_pc_jump", 36'(pc), 36'(6'h3F));
    check("t4_paddr_jump", 36'(prog_addr), 36'(6'h3F));
    repeat (4) tick();                                // cycle 13
    check("t4_paddr_wrap", 36'(prog_addr), 36'(0));
    check("t4_pc_wrap", 36'(pc), 36'(0));
    check("t4_flags_wrap", 36'(flags), 36'(3'b000));
    rd("t4_r8_first", 4'd8, 16'h0124);
    repeat (10) tick();                               // cycle 23, EXEC of pc 63
    check("t4_valid_pre_rst", 36'(alu_valid), 36'(1));
    check("t4_alu_a_pre_rst", 36'(alu_a), 36'(16'h0124));
    check("t4_flags_pre_rst", 36'(flags), 36'(3'b010));
    reset = 1'b1;
    tick();                                           // cycle 24
    check("t4_rst_busy", 36'(busy), 36'(0));
    check("t4_rst_valid", 36'(alu_valid), 36'(0));
    check("t4_rst_flags", 36'(flags), 36'(0));
    check("t4_rst_done", 36'(done), 36'(0));
    check("t4_rst_pc", 36'(pc), 36'(0));
    rd("t4_r5_in_rst", 4'd5, 16'hBEEF);
    reset = 1'b0;
    tick(); tick();
    check("t4_idle_after", 36'(busy), 36'(0));
    rd("t4_r8_kept", 4'd8, 16'h0124);
    rd("t4_r5_after", 4'd5, 16'hBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
